// File: rtl/key_event_arbiter.sv
// Key-press event source: per-key synchroniser and rising-edge detector feeding
// a pending-request register, shared over one valid/ready channel by a round-robin arbiter.
module key_event_arbiter #(
  parameter  int N           = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int IDW         = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   keys,
  input  logic           ev_ready,
  input  logic           clr_overrun,
  output logic           ev_valid,
  output logic [IDW-1:0] ev_id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overrun
);

  typedef enum logic {IDLE, VALID} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     sync_q [SYNC_STAGES];
  logic [N-1:0]     prev_q;
  logic [N-1:0]     key_edge;
  logic [N-1:0]     pending_d, overrun_d, grant_oh, drop;
  logic [IDW-1:0]   ptr_q, ptr_d, grant;
  logic             any_pending, load, grant_en, found;
  int               idx, nxt;

  // NOTE: the whole synchroniser array is reset so a key held through reset
  // still looks like a fresh 0->1 transition once reset releases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= keys;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign key_edge    = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign any_pending = |pending;
  assign load        = ~ev_valid | ev_ready;
  assign grant_en    = load & any_pending;

  // Round-robin scan from ptr, wrapping modulo N (N need not be a power of two).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && pending[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
    nxt = int'(grant) + 1;
    if (nxt >= N) nxt = 0;
    ptr_d = IDW'(nxt);
  end

  always_comb begin
    grant_oh  = grant_en ? (N'(1) << grant) : '0;
    // A granted key re-latches only an edge arriving in the grant cycle.
    pending_d = (pending & ~grant_oh) | key_edge;
    drop      = key_edge & pending & ~grant_oh;
    // Set wins over clear when both land on the same edge.
    overrun_d = drop | (overrun & ~{N{clr_overrun}});
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pending <= '0;
      overrun <= '0;
      ev_id   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      pending <= pending_d;
      overrun <= overrun_d;
      if (grant_en) begin
        ev_id <= grant;
        ptr_q <= ptr_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_pending) state_d = VALID;
      VALID:   if (ev_ready)    state_d = any_pending ? VALID : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ev_valid = (state_q == VALID);
  end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: expected event ids are queued as keys are
// pressed and popped by a monitor at every accepted handshake.
module tb_key_event_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] keys;
  logic         ev_ready;
  logic         clr_overrun;
  logic         ev_valid;
  logic [1:0]   ev_id;
  logic [N-1:0] pending;
  logic [N-1:0] overrun;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int unsigned exp_q[$];

  key_event_arbiter #(.N(N), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .keys(keys), .ev_ready(ev_ready),
    .clr_overrun(clr_overrun), .ev_valid(ev_valid), .ev_id(ev_id),
    .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after each rising edge; outputs are checked there too.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Scoreboard: every accepted event must match the oldest queued id.
  always @(negedge clk) begin
    if (reset === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
      check("event_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_ev_id", 32'(ev_id), exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b0; keys = '0; ev_ready = 1'b1; clr_overrun = 1'b0;
    #1;
    check("rst_ev_valid", 32'(ev_valid), 32'd0);
    check("rst_ev_id",    32'(ev_id),    32'd0);
    check("rst_pending",  32'(pending),  32'd0);
    check("rst_overrun",  32'(overrun),  32'd0);
    tick(2); reset = 1'b1; tick(2);

    // Single press: pending between E2 and E3, one event after E3.
    keys = 4'b0100; exp_q.push_back(2);
    tick(2); check("t1_pending_e1", 32'(pending), 32'h0);
    tick();  check("t1_pending_e2", 32'(pending), 32'h4);
             check("t1_valid_e2",   32'(ev_valid), 32'd0);
    tick();  check("t1_valid_e3",   32'(ev_valid), 32'd1);
             check("t1_id_e3",      32'(ev_id), 32'd2);
             check("t1_pending_e3", 32'(pending), 32'h0);
    tick();  check("t1_valid_e4",   32'(ev_valid), 32'd0);
    tick(6); check("t1_valid_held", 32'(ev_valid), 32'd0);
    keys = '0; tick(4);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // Pulse reset so the round-robin pointer starts from 0.
    reset = 1'b0; tick(); reset = 1'b1; tick();

    // Simultaneous presses: 0, 1, 3 back to back.
    keys = 4'b1011; exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    tick(3); check("t2_pending_e2", 32'(pending), 32'hB);
    tick();  check("t2_id_0", 32'(ev_id), 32'd0);
    tick();  check("t2_id_1", 32'(ev_id), 32'd1);
    tick();  check("t2_id_3", 32'(ev_id), 32'd3);
             check("t2_valid_e5", 32'(ev_valid), 32'd1);
    tick();  check("t2_valid_e6", 32'(ev_valid), 32'd0);
             check("t2_overrun",  32'(overrun), 32'h0);
    keys = '0; tick(3);

    // Fairness: grant 1 leaves ptr=2; then {0,1} -> 0,1 and {1,3} -> 3,1.
    keys = 4'b0010; exp_q.push_back(1);
    tick(4); check("t3_id_1", 32'(ev_id), 32'd1);
    keys = '0; tick(3);
    keys = 4'b0011; exp_q.push_back(0); exp_q.push_back(1);
    tick(4); check("t3_first_0",  32'(ev_id), 32'd0);
    tick();  check("t3_second_1", 32'(ev_id), 32'd1);
    tick();  check("t3_idle",     32'(ev_valid), 32'd0);
    keys = '0; tick(3);
    keys = 4'b1010; exp_q.push_back(3); exp_q.push_back(1);
    tick(4); check("t3_first_3",  32'(ev_id), 32'd3);
    tick();  check("t3_second_1b", 32'(ev_id), 32'd1);
    keys = '0; tick(3);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure with one re-latched press and one dropped press.
    ev_ready = 1'b0; keys = 4'b0100; exp_q.push_back(2);
    tick(4); check("t4_valid", 32'(ev_valid), 32'd1);
             check("t4_id",    32'(ev_id), 32'd2);
    keys = '0; tick(2);
    keys = 4'b0100; tick(); keys = '0; exp_q.push_back(2); tick(3);
    check("t4_pending_1", 32'(pending), 32'h4);
    check("t4_overrun_0", 32'(overrun), 32'h0);
    check("t4_id_held",   32'(ev_id), 32'd2);
    keys = 4'b0100; tick(); keys = '0; tick(3);
    check("t4_overrun_2", 32'(overrun), 32'h4);
    check("t4_pending_2", 32'(pending), 32'h4);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t4_valid_stall", 32'(ev_valid), 32'd1);
      check("t4_id_stall",    32'(ev_id), 32'd2);
    end
    ev_ready = 1'b1;
    tick(); check("t4_reissue_valid", 32'(ev_valid), 32'd1);
            check("t4_reissue_id",    32'(ev_id), 32'd2);
            check("t4_pending_clear", 32'(pending), 32'h0);
    tick(); check("t4_idle", 32'(ev_valid), 32'd0);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // Overrun clear, then clear colliding with a fresh overrun (set wins).
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    check("t5_cleared", 32'(overrun), 32'h0);
    ev_ready = 1'b0; keys = 4'b0100; exp_q.push_back(2);
    tick(); keys = '0; tick(3);
    check("t5_valid", 32'(ev_valid), 32'd1);
    keys = 4'b0100; tick(); keys = '0; exp_q.push_back(2); tick(3);
    check("t5_pending", 32'(pending), 32'h4);
    keys = 4'b0100; tick(); keys = '0; tick();
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    check("t5_set_wins", 32'(overrun), 32'h4);
    ev_ready = 1'b1; tick(2);
    check("t5_idle", 32'(ev_valid), 32'd0);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;

    // Async reset mid-handshake; key 1 held through release gives one event.
    ev_ready = 1'b0; keys = 4'b0001;
    tick(4); keys = '0; tick();
    keys = 4'b1010; tick(); keys = '0; tick(3);
    keys = 4'b0010; tick(); keys = '0; tick(3);
    check("t6_pending_pre", 32'(pending), 32'hA);
    check("t6_overrun_pre", 32'(overrun), 32'h2);
    check("t6_valid_pre",   32'(ev_valid), 32'd1);
    check("t6_id_pre",      32'(ev_id), 32'd0);
    keys = 4'b0010;
    #1 reset = 1'b0;
    #1;
    check("t6_async_valid",   32'(ev_valid), 32'd0);
    check("t6_async_pending", 32'(pending), 32'h0);
    check("t6_async_overrun", 32'(overrun), 32'h0);
    tick(2);
    ev_ready = 1'b1; reset = 1'b1; exp_q.push_back(1);
    tick(4); check("t6_post_valid", 32'(ev_valid), 32'd1);
             check("t6_post_id",    32'(ev_id), 32'd1);
    tick(6); check("t6_post_idle",    32'(ev_valid), 32'd0);
             check("t6_post_pending", 32'(pending), 32'h0);
    keys = '0; tick(2);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_event_arbiter.md
Name: key_event_arbiter

Overview:
- Turns N asynchronous player-input lines (jump/thrust, pause, start, etc.) into single-cycle, clean rising-edge events.
- Each input is synchronised and edge-detected, then held as a pending request.
- A round-robin arbiter shares one valid/ready event channel between the pending requests.
- Sits between the board key pins and the game-control FSM, so each press is consumed exactly once.

Parameters:
N, 4, number of key inputs / requesters (2..16)
SYNC_STAGES, 2, synchroniser flop depth per key (>=2)
IDW, $clog2(N), derived local width of ev_id (not overridable)

Ports:
clk  in  1  system clock; all state updates on its rising edge
reset  in  1  asynchronous, active-low reset (0 = reset); async assert, release sampled on clk
keys  in  N  raw asynchronous key levels, 1 = pressed
ev_ready  in  1  consumer accepts the event this cycle
clr_overrun  in  1  clears overrun flags
ev_valid  out  1  event available on ev_id
ev_id  out  IDW  index of the key that produced the event
pending  out  N  per-key request latched, not yet granted
overrun  out  N  sticky: press dropped because the request was already pending

Behaviour:
- Reset (reset=0): these take 0 immediately, without waiting for a clock edge:
  - all synchroniser flops and the edge-history register
  - pending, overrun, ev_valid, ev_id
  - the round-robin pointer
- Synchroniser: SYNC_STAGES flops per key; sync[i] = last stage.
- Edge history: prev[i] <= sync[i] every cycle.
- Edge detect: edge[i] = sync[i] & ~prev[i], combinational.
- Key held high across reset release: produces exactly one event, because prev resets to 0.
- Pending update at each edge:
  - If edge[i] and key i is not being granted this edge: pending[i] <= 1.
  - If key i is granted this edge: pending[i] <= edge[i]. A new edge arriving in the grant cycle is re-latched, not lost.
  - If edge[i] and pending[i]=1 and i is not granted: the press is dropped and overrun[i] <= 1.
- Output FSM, two states:
  - IDLE (ev_valid=0).
  - VALID (ev_valid=1).
- Load condition: load = ~ev_valid | ev_ready.
- On a clock edge with load=1 and any pending bit set:
  - The grant is the first pending index found scanning ptr, ptr+1, ..., wrapping mod N.
  - ev_id <= grant, ev_valid <= 1, ptr <= (grant+1) mod N.
- On a clock edge with load=1 and no pending bit set: ev_valid <= 0 (return to IDLE).
- Backpressure: while ev_valid=1 and ev_ready=0, ev_id and ev_valid are held stable and the arbiter makes no grant.
- Throughput: with ev_ready held at 1, one event per cycle.
- Fairness: a requester waits at most N-1 grants.
- Latency: a key first sampled high at edge E0 gives synced high at E(SYNC_STAGES-1), pending at E(SYNC_STAGES), ev_valid at E(SYNC_STAGES+1) when the channel is idle.
- Arbitration considers registered pending only; there is no edge-to-grant bypass.
- Overrun: stays set until a clock edge with clr_overrun=1. If clr_overrun and a new overrun for the same bit occur on the same edge, set wins.
- Releasing a key generates no event. There is no debounce: bounce produces multiple events, and filtering is the consumer's job.
- Reset asserted mid-handshake: the event is dropped with no partial state. The first event after release must be a fresh edge.

Test Plan:
1. N=4, SYNC_STAGES=2, ev_ready=1. keys[2] 0->1 before edge E0, held 10 cycles -> ev_valid=1, ev_id=2 after E3 for exactly one cycle; pending[2] high only between E2 and E3; no further events.
2. keys[0], keys[1], keys[3] rise together, ev_ready=1 -> ev_id = 0, 1, 3 on three consecutive cycles, then ev_valid=0; final ptr=0; overrun=0.
3. Fairness: after a grant of id 1 (ptr=2), keys 0 and 1 both become pending -> grant order 0 then 1, since the scan runs 2, 3, 0.
4. Backpressure: ev_valid=1, ev_id=2, ev_ready=0 for 12 cycles. keys[2] pulses once -> pending[2]=1, overrun=0, ev_id stays 2. A second keys[2] pulse -> overrun[2]=1. Then ev_ready=1 -> the event for id 2 is accepted, id 2 is re-issued next cycle, then ev_valid=0.
5. Overrun clear: overrun[2]=1; pulse clr_overrun for one cycle -> overrun=0. Repeat with clr_overrun coinciding with a new overrun edge -> overrun[2] stays 1.
6. Async reset mid-operation: with ev_valid=1 and pending=4'b1010, drive reset=0 between clock edges -> ev_valid, pending, overrun all 0 before the next edge. Release reset with keys[1] held high -> exactly one event, ev_id=1.
